// File: rtl/mdu_hilo.sv
// Multiply/divide unit beside EXE: owns HI/LO, runs MULT/MULTU in one busy cycle
// and DIV/DIVU as a 32-step restoring divider followed by a sign-fix cycle.
module mdu_hilo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              md_valid_in,
    input  logic [5:0]        md_op_in,
    input  logic [DATA_W-1:0] md_in0_in,
    input  logic [DATA_W-1:0] md_in1_in,
    input  logic              md_rd_hi_in,
    input  logic              md_clr_in,
    output logic              md_ready_out,
    output logic [DATA_W-1:0] md_rdata_out,
    output logic              md_busy_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [32:0] ma_q, ma_d;
    logic [32:0] mb_q, mb_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        ready_q, ready_d;

    logic        op_onehot;
    logic        accept;
    logic [65:0] product;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        op_onehot = (md_op_in != 6'd0) && ((md_op_in & (md_op_in - 6'd1)) == 6'd0);
        accept    = md_valid_in && (state_q == S_IDLE) && !md_clr_in && op_onehot;

        // Low 66 bits of the unsigned product of sign-extended operands equal the signed product.
        product = {{33{ma_q[32]}}, ma_q} * {{33{mb_q[32]}}, mb_q};

        rem_sh = {rem_q, dvd_q[31]};
        rem_ge = (rem_sh >= {1'b0, dvs_q});

        a_mag = (md_op_in[3] && md_in0_in[31]) ? (32'd0 - md_in0_in) : md_in0_in;
        b_mag = (md_op_in[3] && md_in1_in[31]) ? (32'd0 - md_in1_in) : md_in1_in;

        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;

        if (md_clr_in) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (md_op_in[5] || md_op_in[4]) begin
                            ma_d    = {md_op_in[5] & md_in0_in[31], md_in0_in};
                            mb_d    = {md_op_in[5] & md_in1_in[31], md_in1_in};
                            state_d = S_MUL;
                        end else if (md_op_in[3] || md_op_in[2]) begin
                            // Divide by zero is swallowed without a busy cycle.
                            if (md_in1_in != 32'd0) begin
                                dvd_d   = a_mag;
                                dvs_d   = b_mag;
                                rem_d   = 32'd0;
                                cnt_d   = 5'd0;
                                q_neg_d = md_op_in[3] & (md_in0_in[31] ^ md_in1_in[31]);
                                r_neg_d = md_op_in[3] & md_in0_in[31];
                                state_d = S_DIV;
                            end
                        end else if (md_op_in[1]) begin
                            hi_d = md_in1_in;
                        end else begin
                            lo_d = md_in1_in;
                        end
                    end
                end
                S_MUL: begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    state_d = S_IDLE;
                end
                S_DIV: begin
                    rem_d = rem_ge ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
                    dvd_d = {dvd_q[30:0], rem_ge};
                    if (cnt_q == 5'd31) begin
                        cnt_d   = 5'd0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_FIX: begin
                    lo_d    = q_neg_q ? (32'd0 - dvd_q) : dvd_q;
                    hi_d    = r_neg_q ? (32'd0 - rem_q) : rem_q;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            ma_q    <= 33'd0;
            mb_q    <= 33'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            rem_q   <= 32'd0;
            cnt_q   <= 5'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            ready_q <= ready_d;
        end
    end

    assign md_ready_out = ready_q;
    assign md_busy_out  = ~ready_q;
    assign md_rdata_out = md_rd_hi_in ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: HI/LO moves, mult/div results, busy lengths,
// flush and async-reset behaviour, all against hand-computed values.
module tb_mdu_hilo;

    localparam logic [5:0] OP_MULT  = 6'b100000;
    localparam logic [5:0] OP_MULTU = 6'b010000;
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000010;
    localparam logic [5:0] OP_MTLO  = 6'b000001;

    logic        clk;
    logic        rst_n;
    logic        md_valid_in;
    logic [5:0]  md_op_in;
    logic [31:0] md_in0_in;
    logic [31:0] md_in1_in;
    logic        md_rd_hi_in;
    logic        md_clr_in;
    logic        md_ready_out;
    logic [31:0] md_rdata_out;
    logic        md_busy_out;

    int errors = 0;
    int checks = 0;
    int n;

    mdu_hilo #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .md_valid_in  (md_valid_in),
        .md_op_in     (md_op_in),
        .md_in0_in    (md_in0_in),
        .md_in1_in    (md_in1_in),
        .md_rd_hi_in  (md_rd_hi_in),
        .md_clr_in    (md_clr_in),
        .md_ready_out (md_ready_out),
        .md_rdata_out (md_rdata_out),
        .md_busy_out  (md_busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request mid-cycle, hold it across one rising edge.
    task automatic do_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        md_valid_in = 1'b1;
        md_op_in    = op;
        md_in0_in   = a;
        md_in1_in   = b;
        @(posedge clk);
        #1;
        md_valid_in = 1'b0;
        md_op_in    = 6'd0;
    endtask

    // Counts edges until ready returns, bounded so a stuck DUT still reaches the summary.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (!md_ready_out && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic read_check(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        md_rd_hi_in = 1'b1;
        #1;
        check({tag, "_hi"}, md_rdata_out, hi_exp);
        md_rd_hi_in = 1'b0;
        #1;
        check({tag, "_lo"}, md_rdata_out, lo_exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        md_valid_in = 1'b0;
        md_op_in    = 6'd0;
        md_in0_in   = 32'd0;
        md_in1_in   = 32'd0;
        md_rd_hi_in = 1'b0;
        md_clr_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, md_ready_out}, 32'd1);
        check("rst_busy", {31'd0, md_busy_out}, 32'd0);
        read_check("rst", 32'd0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MTHI / MTLO, including the old-value read while the move is pending.
        do_req(OP_MTHI, 32'd0, 32'h1234_5678);
        check("mthi_ready", {31'd0, md_ready_out}, 32'd1);
        md_valid_in = 1'b1;
        md_op_in    = OP_MTLO;
        md_in1_in   = 32'h9ABC_DEF0;
        md_rd_hi_in = 1'b0;
        #1;
        check("mtlo_old_read", md_rdata_out, 32'd0);
        @(posedge clk);
        #1;
        md_valid_in = 1'b0;
        md_op_in    = 6'd0;
        check("mtlo_ready", {31'd0, md_ready_out}, 32'd1);
        read_check("mthilo", 32'h1234_5678, 32'h9ABC_DEF0);

        // Non-one-hot op is ignored.
        do_req(6'b000011, 32'd0, 32'hDEAD_BEEF);
        check("bad_op_ready", {31'd0, md_ready_out}, 32'd1);
        read_check("bad_op", 32'h1234_5678, 32'h9ABC_DEF0);

        do_req(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        check("mult_busy_out", {31'd0, md_busy_out}, 32'd1);
        wait_idle(n);
        check("mult_cycles", n, 32'd1);
        read_check("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        do_req(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle(n);
        check("multu_cycles", n, 32'd1);
        read_check("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        do_req(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_cycles", n, 32'd33);
        read_check("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        do_req(OP_DIVU, 32'd100, 32'd7);
        wait_idle(n);
        check("divu_cycles", n, 32'd33);
        read_check("divu_100_7", 32'd2, 32'd14);

        do_req(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        read_check("div_ovf", 32'd0, 32'h8000_0000);

        do_req(OP_DIVU, 32'd5, 32'd0);
        check("div0_ready", {31'd0, md_ready_out}, 32'd1);
        read_check("div0", 32'd0, 32'h8000_0000);

        // Flush ten cycles into a divide.
        do_req(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        check("clr_div_busy", {31'd0, md_ready_out}, 32'd0);
        md_clr_in = 1'b1;
        @(posedge clk);
        #1;
        md_clr_in = 1'b0;
        check("clr_div_ready", {31'd0, md_ready_out}, 32'd1);
        read_check("clr_div", 32'd0, 32'h8000_0000);
        repeat (40) @(posedge clk);
        #1;
        read_check("clr_div_late", 32'd0, 32'h8000_0000);

        // Flush on the multiply completion edge.
        do_req(OP_MULT, 32'd7, 32'd9);
        md_clr_in = 1'b1;
        @(posedge clk);
        #1;
        md_clr_in = 1'b0;
        check("clr_mul_ready", {31'd0, md_ready_out}, 32'd1);
        read_check("clr_mul", 32'd0, 32'h8000_0000);

        // A move issued while dividing is dropped.
        do_req(OP_DIVU, 32'd1000, 32'd3);
        md_valid_in = 1'b1;
        md_op_in    = OP_MTLO;
        md_in1_in   = 32'h0000_0055;
        repeat (3) @(posedge clk);
        #1;
        md_valid_in = 1'b0;
        md_op_in    = 6'd0;
        wait_idle(n);
        check("busy_drop_ready", {31'd0, md_ready_out}, 32'd1);
        read_check("busy_drop", 32'd1, 32'd333);

        // Asynchronous reset mid-divide, checked before any clock edge.
        do_req(OP_DIVU, 32'd77, 32'd5);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, md_ready_out}, 32'd1);
        check("arst_busy", {31'd0, md_busy_out}, 32'd0);
        md_rd_hi_in = 1'b1;
        #0.5;
        check("arst_hi", md_rdata_out, 32'd0);
        md_rd_hi_in = 1'b0;
        #0.5;
        check("arst_lo", md_rdata_out, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_arst_ready", {31'd0, md_ready_out}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide responder for the EXE stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests issued from EXE, runs them on its own datapath, and owns the architectural HI/LO registers.
- It gives EXE a ready signal for stalling, and serves MFHI/MFLO reads.
- It sits beside EXE. Its results are read by the MEM/WB select path.

Parameters:
- DATA_W, 32, operand/HI/LO width. Only 32 is supported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- md_valid_in  in  1  request strobe from EXE; already qualified with exe_valid and no exception
- md_op_in  in  6  one-hot {mult, multu, div, divu, mthi, mtlo}, bit5..bit0
- md_in0_in  in  32  rs operand (dividend / multiplicand)
- md_in1_in  in  32  rt operand (divisor / multiplier); also the data for mthi/mtlo
- md_rd_hi_in  in  1  read select: 1 = HI, 0 = LO
- md_clr_in  in  1  pipeline flush (wb_ClrStpJmp); aborts any operation in flight
- md_ready_out  out  1  1 = idle; a request may be accepted and HI/LO may be read
- md_rdata_out  out  32  registered HI or LO, selected by md_rd_hi_in
- md_busy_out  out  1  complement of md_ready_out, for the hazard unit

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, HI = LO = 0, counter = 0.
  - md_ready_out = 1, md_busy_out = 0, md_rdata_out = 0.
- Acceptance:
  - A request is accepted at a clk edge when md_valid_in = 1, state = IDLE and md_clr_in = 0.
  - md_op_in that is not one-hot, or is zero, is ignored with no state change.
- md_rdata_out:
  - Combinational mux of the HI/LO registers.
  - A read in the same cycle as an accepted mthi/mtlo returns the old value.
- MTHI/MTLO:
  - HI (or LO) <= md_in1_in at the accept edge.
  - State stays IDLE; md_ready_out never drops.
- States: IDLE, MUL, DIV, FIX.
- MUL/MULTU:
  - Accept edge: latch operands sign/zero-extended to 33 bits. IDLE -> MUL.
  - In MUL, the 33x33 signed product is computed.
  - Next edge: {HI, LO} <= product[63:0], MUL -> IDLE.
  - md_ready_out = 0 for exactly 1 cycle.
- DIV/DIVU:
  - Accept edge:
    - If md_in1_in == 0: no state change, HI/LO unchanged, stays IDLE (0-cycle busy).
    - Otherwise: latch the magnitudes |a|, |b| (signed op) or raw values (unsigned), and the sign flags. Clear the remainder, counter = 0. IDLE -> DIV.
  - DIV: restoring radix-2, one quotient bit per cycle, MSB first.
    - After the cycle with counter == 31: DIV -> FIX.
    - Counter increments by 1 each cycle, 5 bits, no wrap beyond 31.
  - FIX: apply signs, then go to IDLE.
    - LO <= quotient, negated if sign(a) ^ sign(b) (signed op only).
    - HI <= remainder, negated if sign(a) (signed op only).
  - Total md_ready_out = 0 for 33 cycles: 32 in DIV, 1 in FIX.
  - 0x80000000 / 0xFFFFFFFF signed: LO = 0x80000000, HI = 0 (wraps; no trap).
- md_clr_in = 1 at any edge:
  - state -> IDLE, counter cleared.
  - HI/LO are not written by the aborted operation.
  - A request in the same cycle is dropped.
  - md_clr_in takes priority over acceptance and over completion in MUL/FIX; e.g. clr on the MUL completion edge leaves HI/LO unchanged.
- EXE contract (not checked by this block):
  - EXE stalls (its ready = md_ready_out) while a new mult/div/mfhi/mflo/mthi/mtlo is pending and md_ready_out = 0.
  - md_valid_in asserted while busy is ignored.
- Reset asserted mid-operation: immediate return to IDLE, HI = LO = 0.

Test Plan:
- Reset, then MTHI 0x12345678 followed by MTLO 0x9ABCDEF0 → reading with md_rd_hi_in = 1 gives 0x12345678 and with md_rd_hi_in = 0 gives 0x9ABCDEF0; md_ready_out stays 1 throughout.
- MULT 0xFFFFFFFE × 0x00000003 → 1 busy cycle, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU of the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 → md_ready_out low for exactly 33 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. DIVU 5 / 0 → HI/LO unchanged and md_ready_out never drops.
- Start DIVU 1000/3, assert md_clr_in at cycle 10 → IDLE on the next cycle with HI/LO holding their pre-request values. Repeat with clr on the MUL completion edge → HI/LO unchanged.
- Assert md_valid_in (MTLO 0x55) while a DIV is busy → ignored, LO = quotient afterwards. Assert rst_n = 0 asynchronously mid-DIV → HI = LO = 0 and md_ready_out = 1 without waiting for a clk edge.
